expr_gen: RTL and testbench

Stimulus-side companion to the expression checker. It emits a character stream of the form digit (op digit)*, one byte per accepted cycle, using digits '0'–'9' and operators '+' and '*'. Digits and operators come from a seeded 8-bit LFSR, so every frame is deterministic. The block drives the checker's `in` port in system and self-test benches, and can optionally end a frame on an operator to produce a deliberately illegal stream.

---
 rtl/expr_gen_if.sv | 44 ++++
 rtl/expr_gen.sv | 156 +++++++++++++++
 tb/tb_expr_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/expr_gen_if.sv
// ============================================================================
// Module      : expr_gen_if
// Description : Request/stream bundle between a controller and expr_gen.
//               The controller supplies the frame request (start, len, seed),
//               the downstream stall (hold) and, when EXPR_GEN_ERR_EN is
//               defined, the inject flag. expr_gen returns the character
//               stream (out, valid, sof) and frame status (busy, done).
// Modports    : master - controller side (drives request/hold)
//               slave  - expr_gen side (drives stream/status)
// Macro       : EXPR_GEN_ERR_EN adds the inject signal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface expr_gen_if #(
  parameter int LEN_W = 4
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic [7:0]       seed;
  logic             hold;
`ifdef EXPR_GEN_ERR_EN
  logic             inject;
`endif
  logic [7:0]       out;
  logic             valid;
  logic             sof;
  logic             busy;
  logic             done;

`ifdef EXPR_GEN_ERR_EN
  modport master (output start, len, seed, hold, inject,
                  input  out, valid, sof, busy, done);
  modport slave  (input  start, len, seed, hold, inject,
                  output out, valid, sof, busy, done);
`else
  modport master (output start, len, seed, hold,
                  input  out, valid, sof, busy, done);
  modport slave  (input  start, len, seed, hold,
                  output out, valid, sof, busy, done);
`endif
endinterface

`default_nettype wire

// File: rtl/expr_gen.sv
// ============================================================================
// Module      : expr_gen
// Description : Emits an ASCII expression stream "digit (op digit)*" with
//               digits '0'-'9' and operators '+'/'*', drawn from a seeded
//               8-bit Fibonacci LFSR. One character per accepted cycle
//               (valid && !hold); done pulses once after the last accept.
// Ports       : clk  - clock, rising edge
//               clr  - asynchronous active-high reset
//               bus  - expr_gen_if.slave (start/len/seed/hold[/inject] in,
//                      out/valid/sof/busy/done out, all outputs registered)
// Macro       : EXPR_GEN_ERR_EN - adds inject; when latched high the last
//               digit is replaced by an operator, making the frame illegal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module expr_gen #(
  parameter int LEN_W = 4
) (
  input  wire           clk,
  input  wire           clr,
  expr_gen_if.slave     bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIGIT = 2'd1;
  localparam logic [1:0] S_OP    = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [LEN_W-1:0] c_zero = '0;
  localparam logic [LEN_W-1:0] c_one  = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [7:0]       r_lfsr;
  logic [LEN_W-1:0] r_cnt;
  logic [7:0]       r_out;
  logic             r_valid;
  logic             r_sof;
  logic             r_busy;
  logic             r_done;

  logic [7:0]       w_lfsr_next;
  logic [7:0]       w_seed;
  logic             w_accept;
  logic             w_inj_start;
  logic             w_inj_frame;

  function automatic logic [7:0] f_digit(input logic [7:0] s);
    logic [3:0] n;
    n = s[3:0];
    if (n >= 4'd10) n = n - 4'd10;
    return 8'h30 + {4'h0, n};
  endfunction

  function automatic logic [7:0] f_op(input logic [7:0] s);
    return s[0] ? 8'h2A : 8'h2B;
  endfunction

  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  // An all-zero seed would lock the LFSR.
  assign w_seed      = (bus.seed == 8'h00) ? 8'h01 : bus.seed;
  assign w_accept    = r_valid && !bus.hold;

`ifdef EXPR_GEN_ERR_EN
  logic r_inject;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_inject <= 1'b0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_inject <= bus.inject;
    end
  end

  assign w_inj_start = bus.inject;
  assign w_inj_frame = r_inject;
`else
  assign w_inj_start = 1'b0;
  assign w_inj_frame = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_lfsr  <= 8'h01;
      r_cnt   <= c_zero;
      r_out   <= 8'h00;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            if (bus.len != c_zero) begin
              r_state <= S_DIGIT;
              r_lfsr  <= w_seed;
              r_cnt   <= bus.len;
              // A single-digit frame's first digit is also its last one.
              r_out   <= (w_inj_start && bus.len == c_one) ? f_op(w_seed) : f_digit(w_seed);
              r_valid <= 1'b1;
              r_sof   <= 1'b1;
            end else begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end
          end
        end

        S_DIGIT: begin
          if (w_accept) begin
            r_lfsr <= w_lfsr_next;
            r_cnt  <= r_cnt - c_one;
            r_sof  <= 1'b0;
            if (r_cnt != c_one) begin
              r_state <= S_OP;
              r_out   <= f_op(w_lfsr_next);
            end else begin
              r_state <= S_FIN;
              r_out   <= 8'h00;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end

        S_OP: begin
          if (w_accept) begin
            r_lfsr  <= w_lfsr_next;
            r_sof   <= 1'b0;
            r_state <= S_DIGIT;
            // r_cnt counts digits still to emit; 1 means the next is last.
            r_out   <= (w_inj_frame && r_cnt == c_one) ? f_op(w_lfsr_next) : f_digit(w_lfsr_next);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out   = r_out;
  assign bus.valid = r_valid;
  assign bus.sof   = r_sof;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_expr_gen.sv
// ============================================================================
// Module      : tb_expr_gen
// Description : Directed self-checking bench for expr_gen. Inputs change 1
//               time unit after each rising edge; outputs are sampled there.
// Macro       : EXPR_GEN_ERR_EN enables the inject steps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_expr_gen;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  expr_gen_if #(.LEN_W(4)) bus ();

  expr_gen #(.LEN_W(4)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] o, input logic v,
                         input logic s, input logic b, input logic d);
    chk({tag, ".out"},   {24'h0, bus.out}, {24'h0, o});
    chk({tag, ".valid"}, {31'h0, bus.valid}, {31'h0, v});
    chk({tag, ".sof"},   {31'h0, bus.sof},   {31'h0, s});
    chk({tag, ".busy"},  {31'h0, bus.busy},  {31'h0, b});
    chk({tag, ".done"},  {31'h0, bus.done},  {31'h0, d});
  endtask

  task automatic req(input logic [3:0] l, input logic [7:0] sd, input logic inj);
    bus.start = 1'b1;
    bus.len   = l;
    bus.seed  = sd;
`ifdef EXPR_GEN_ERR_EN
    bus.inject = inj;
`else
    if (inj) $display("note: inject ignored in this build");
`endif
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.len   = '0;
    bus.seed  = 8'h00;
    bus.hold  = 1'b0;
`ifdef EXPR_GEN_ERR_EN
    bus.inject = 1'b0;
`endif
    #12;
    chk_all("reset", 8'h00, 0, 0, 0, 0);
    clr = 1'b0;
    tick();

    // seed 05, len 2: "5+5", done on the 4th cycle
    req(4'd2, 8'h05, 1'b0);
    chk_all("f1.c0", 8'h35, 1, 1, 1, 0);
    tick(); chk_all("f1.c1", 8'h2B, 1, 0, 1, 0);
    tick(); chk_all("f1.c2", 8'h35, 1, 0, 1, 0);
    tick(); chk_all("f1.done", 8'h00, 0, 0, 1, 1);
    tick(); chk_all("f1.idle", 8'h00, 0, 0, 0, 0);

    // seed 0C, len 1: digit 12 wraps to "2"
    req(4'd1, 8'h0C, 1'b0);
    chk_all("f2.c0", 8'h32, 1, 1, 1, 0);
    tick(); chk_all("f2.done", 8'h00, 0, 0, 1, 1);
    tick(); chk_all("f2.idle", 8'h00, 0, 0, 0, 0);

    // holds: one cycle on the first char, three on the "+"
    req(4'd2, 8'h05, 1'b0);
    bus.hold = 1'b1;
    tick(); chk_all("f3.hold0", 8'h35, 1, 1, 1, 0);
    bus.hold = 1'b0;
    tick(); chk_all("f3.c1", 8'h2B, 1, 0, 1, 0);
    bus.hold = 1'b1;
    tick(); chk_all("f3.h1", 8'h2B, 1, 0, 1, 0);
    tick(); chk_all("f3.h2", 8'h2B, 1, 0, 1, 0);
    tick(); chk_all("f3.h3", 8'h2B, 1, 0, 1, 0);
    bus.hold = 1'b0;
    tick(); chk_all("f3.c2", 8'h35, 1, 0, 1, 0);
    tick(); chk_all("f3.done", 8'h00, 0, 0, 1, 1);
    tick();

    // len 0: straight to done, valid never rises
    req(4'd0, 8'h05, 1'b0);
    chk_all("f4.done", 8'h00, 0, 0, 1, 1);
    tick(); chk_all("f4.idle", 8'h00, 0, 0, 0, 0);

    // start pulsed mid-frame with different len/seed: ignored
    req(4'd2, 8'h05, 1'b0);
    chk_all("f5.c0", 8'h35, 1, 1, 1, 0);
    bus.start = 1'b1; bus.len = 4'd1; bus.seed = 8'h0C;
    tick(); chk_all("f5.c1", 8'h2B, 1, 0, 1, 0);
    tick(); chk_all("f5.c2", 8'h35, 1, 0, 1, 0);
    bus.start = 1'b0;
    tick(); chk_all("f5.done", 8'h00, 0, 0, 1, 1);
    tick(); chk_all("f5.idle", 8'h00, 0, 0, 0, 0);

    // clr on the 2nd char of a len-5 frame: immediate reset, no resume
    req(4'd5, 8'h05, 1'b0);
    tick(); chk_all("f6.c1", 8'h2B, 1, 0, 1, 0);
    #2 clr = 1'b1;
    #1 chk_all("f6.clr", 8'h00, 0, 0, 0, 0);
    tick();
    clr = 1'b0;
    tick(); chk_all("f6.after", 8'h00, 0, 0, 0, 0);
    req(4'd2, 8'h05, 1'b0);
    chk_all("f7.c0", 8'h35, 1, 1, 1, 0);
    tick(); chk_all("f7.c1", 8'h2B, 1, 0, 1, 0);
    tick(); chk_all("f7.c2", 8'h35, 1, 0, 1, 0);
    tick(); chk_all("f7.done", 8'h00, 0, 0, 1, 1);
    tick();

    // zero seed behaves as seed 01: "1"
    req(4'd1, 8'h00, 1'b0);
    chk_all("f8.c0", 8'h31, 1, 1, 1, 0);
    tick(); tick();

`ifdef EXPR_GEN_ERR_EN
    // inject: "5+*" (last LFSR state 15 has bit0 set)
    req(4'd2, 8'h05, 1'b1);
    bus.inject = 1'b0;
    chk_all("i1.c0", 8'h35, 1, 1, 1, 0);
    tick(); chk_all("i1.c1", 8'h2B, 1, 0, 1, 0);
    tick(); chk_all("i1.c2", 8'h2A, 1, 0, 1, 0);
    tick(); chk_all("i1.done", 8'h00, 0, 0, 1, 1);
    tick();
    // inject with len 1, seed 0C: operator from bit0=0 -> "+"
    req(4'd1, 8'h0C, 1'b1);
    bus.inject = 1'b0;
    chk_all("i2.c0", 8'h2B, 1, 1, 1, 0);
    tick(); tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
